// File: rtl/uart_tx.sv
// uart_tx: 8N1-style UART transmitter with a free bit-period divider; optional parity bit.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when parityOdd=1) after the data bits.
module uart_tx #(
    parameter int bits      = 8,
    parameter int clkFreq   = 32000000,
    parameter int baudRate  = 115200,
    parameter bit parityOdd = 1'b0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [bits-1:0] Data,
    input  logic            WR,
    output logic            TX,
    output logic            BUSY,
    output logic            DONE
);
    localparam int DIV = clkFreq / baudRate;
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(bits);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    logic r_par;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state, w_next;
    logic [DW-1:0]   r_div;
    logic [CW-1:0]   r_cnt;
    logic [bits-1:0] r_shift;
    logic            r_done;
    logic            w_tick, w_last, w_tx;

    assign w_tick = r_div == DW'(DIV - 1);
    assign w_last = r_cnt == CW'(bits - 1);

    always_comb begin
        w_next = r_state;
        w_tx   = 1'b1;
        case (r_state)
            S_IDLE:   w_next = WR ? S_START : S_IDLE;
            S_START: begin
                w_tx   = 1'b0;
                w_next = w_tick ? S_DATA : S_START;
            end
            S_DATA: begin
                w_tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
                w_next = (w_tick && w_last) ? S_PARITY : S_DATA;
`else
                w_next = (w_tick && w_last) ? S_STOP : S_DATA;
`endif
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx   = r_par;
                w_next = w_tick ? S_STOP : S_PARITY;
            end
`endif
            S_STOP:   w_next = w_tick ? S_IDLE : S_STOP;
            default:  w_next = S_IDLE;
        endcase
    end

    // Shift register and parity are captured together so later Data changes cannot leak into the frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_STOP) && w_tick;
            if (r_state == S_IDLE) begin
                r_div <= '0;
                r_cnt <= '0;
                if (WR) begin
                    r_shift <= Data;
`ifdef UART_TX_PARITY_EN
                    r_par   <= (^Data) ^ parityOdd;
`endif
                end
            end else begin
                r_div <= w_tick ? '0 : r_div + DW'(1);
                if (r_state == S_DATA && w_tick) begin
                    r_shift <= r_shift >> 1;
                    r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
                end
            end
        end
    end

    assign TX   = w_tx;
    assign BUSY = r_state != S_IDLE;
    assign DONE = r_done;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed checks of uart_tx against a frame-level reference model and a line-level receiver.
module tb_uart_tx;
    localparam int DIV  = 16;
    localparam bit PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB    = 8 + 2 + P;
    localparam int FRAME = NB * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic       wr = 1'b0;
    logic       tx, busy, done;

    int n_vec = 0;
    int n_err = 0;

    int        m_left = 0;
    bit        m_done = 1'b0;
    bit        m_acc  = 1'b0;
    bit [15:0] m_frame = '0;

    int        rx_t = -1;
    bit [8:0]  rx_sh = '0;
    bit [8:0]  rx_q[$];

    uart_tx #(.bits(8), .clkFreq(16), .baudRate(1), .parityOdd(PODD)) dut (
        .CLK(clk), .RST(rst), .Data(data), .WR(wr), .TX(tx), .BUSY(busy), .DONE(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame as a bit list: start, data LSB first, optional parity, stop.
    task automatic model_edge();
        m_acc = 1'b0;
        if (!rst) begin
            m_left = 0;
            m_done = 1'b0;
        end else begin
            m_done = (m_left == 1);
            if (m_left > 0) m_left--;
            else if (wr) begin
                m_left  = FRAME;
                m_frame = '0;
                m_frame[8:1] = data;
`ifdef UART_TX_PARITY_EN
                m_frame[9] = (^data) ^ PODD;
`endif
                m_frame[NB-1] = 1'b1;
                m_acc = 1'b1;
            end
        end
    endtask

    task automatic rx_sample();
        int k;
        if (!rst) rx_t = -1;
        else if (rx_t < 0) begin
            if (tx == 1'b0) rx_t = 0;
        end else rx_t++;
        if (rx_t >= DIV / 2 && (rx_t - DIV / 2) % DIV == 0) begin
            k = (rx_t - DIV / 2) / DIV;
            if (k >= 1 && k <= 8) rx_sh[k-1] = tx;
            if (k == NB - 1) begin
                rx_sh[8] = tx;
                rx_q.push_back(rx_sh);
                rx_t = -1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("tx", tx, (m_left == 0) ? 1'b1 : m_frame[(FRAME - m_left) / DIV]);
        check("busy", busy, m_left > 0);
        check("done", done, m_done);
        rx_sample();
    endtask

    task automatic send(input logic [7:0] d, input int n);
        data = d;
        wr   = 1'b1;
        cyc();
        wr = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        int cnt;
        int guard;
        wr = 1'b1;
        data = 8'hC3;
        repeat (3) cyc();
        wr = 1'b0;
        rst = 1'b1;
        cyc();
        send(8'hA5, FRAME + 4);
        send(8'h07, FRAME + 4);
        send(8'h55, 39);
        send(8'hFF, FRAME + 10);
        data = 8'h00;
        wr = 1'b1;
        repeat (2 * FRAME + 2) cyc();
        wr = 1'b0;
        repeat (FRAME) cyc();
        send(8'h55, 49);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        repeat (3) cyc();
        send(8'h3C, FRAME + 4);
        repeat (3000) begin
            wr   = ($urandom_range(0, 3) == 0);
            data = 8'($urandom);
            rst  = ($urandom_range(0, 499) != 0);
            cyc();
        end
        wr  = 1'b0;
        rst = 1'b1;
        repeat (FRAME + 20) cyc();
        rx_q.delete();
        cnt = 0;
        guard = 0;
        data = 8'h00;
        wr = 1'b1;
        while (cnt < 256 && guard < 256 * (FRAME + 2) + 100) begin
            cyc();
            guard++;
            if (m_acc) begin
                cnt++;
                data = 8'(cnt);
                if (cnt == 256) wr = 1'b0;
            end
        end
        wr = 1'b0;
        check("line_accepts", cnt, 256);
        repeat (FRAME + 10) cyc();
        check("line_count", rx_q.size(), 256);
        for (int i = 0; i < 256 && i < rx_q.size(); i++)
            check("line_byte", rx_q[i], {1'b1, 8'(i)});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
